// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage store buffer.
// Word/byte widths and the store-buffer entry layout.
package mem_pkg;

    localparam int DM_AW  = 10;
    localparam int WORD_W = 32;
    localparam int EA_W   = DM_AW - 2;

    typedef struct packed {
        logic [EA_W-1:0]   addr;
        logic [WORD_W-1:0] data;
    } sb_entry_t;

    function automatic logic [WORD_W-1:0] byte_sel(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        off
    );
        logic [7:0] b;
        unique case (off)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
            default: b = word[7:0];
        endcase
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/mem_store_buffer_sb_match.sv
// Youngest-match search over the store-buffer entries.
// Walks from head toward tail; the last live hit wins.
module sb_match
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            i_valid,
    input  logic [DEPTH-1:0][EA_W-1:0]  i_addr,
    input  logic [PW-1:0]               i_head,
    input  logic [EA_W-1:0]             i_ld_addr,
    output logic                        o_hit,
    output logic [PW-1:0]               o_idx
);

    logic [PW-1:0] w_idx;

    // Scan oldest to youngest so the youngest live match overrides.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if (i_valid[w_idx] && (i_addr[w_idx] == i_ld_addr)) begin
                o_hit = 1'b1;
                o_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between MEM stage and data memory.
// MEM_STORE_BUFFER_FWD_EN enables load forwarding; else hits drain first.
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DM_AW,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    input  logic          ld_lb,
    output logic          ld_stall,
    output logic          ld_fwd,
    output logic [31:0]   ld_fwd_data,
    output logic          dm_MemWr,
    output logic [31:0]   dm_Addr,
    output logic [31:0]   dm_Data_in,
    output logic          dm_lb_sel,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic                       w_full;
    logic                       w_nempty;
    logic                       w_enq;
    logic                       w_drain;
    logic                       w_hit;
    logic [PW-1:0]              w_hit_idx;
    logic [DEPTH-1:0]           w_valid;
    logic [DEPTH-1:0][EA_W-1:0] w_addrs;
    logic [EA_W-1:0]            w_ld_wa;
    logic [EA_W-1:0]            w_st_wa;
    sb_entry_t                  w_head_e;
    logic                       w_unused_bits;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_nempty = (r_count != '0);
    assign w_enq    = st_valid & ~w_full;
    assign w_ld_wa  = EA_W'(ld_addr[AW-1:2]);
    assign w_st_wa  = EA_W'(st_addr[AW-1:2]);
    assign w_head_e = r_mem[r_head];

    // Byte offset bits of stores and high address bits never reach dm.
    assign w_unused_bits = ^{st_addr[31:AW], st_addr[1:0],
                             ld_addr[31:AW]};

    // Live mask: entries at offsets [0, count) from head are valid.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = (CW'(PW'(i) - r_head) < r_count);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_addr
        assign w_addrs[g] = r_mem[g].addr;
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_match (
        .i_valid   (w_valid),
        .i_addr    (w_addrs),
        .i_head    (r_head),
        .i_ld_addr (w_ld_wa),
        .o_hit     (w_hit),
        .o_idx     (w_hit_idx)
    );

`ifdef MEM_STORE_BUFFER_FWD_EN
    logic [WORD_W-1:0] w_hit_data;

    assign w_hit_data = r_mem[w_hit_idx].data;
    assign w_drain    = w_nempty & (~ld_valid | w_full);
    assign ld_stall   = ld_valid & (w_full | st_valid);
    assign ld_fwd     = ld_valid & w_hit & ~ld_stall;

    // Forwarded word, or its zero-extended byte for lb.
    always_comb begin
        ld_fwd_data = '0;
        if (ld_fwd) begin
            ld_fwd_data = ld_lb ? byte_sel(w_hit_data, ld_addr[1:0])
                                : w_hit_data;
        end
    end
`else
    logic w_unused_idx;

    assign w_unused_idx = ^w_hit_idx;
    assign w_drain      = w_nempty & (~ld_valid | w_full | w_hit);
    assign ld_stall     = ld_valid & (w_full | st_valid | w_hit);
    assign ld_fwd       = 1'b0;
    assign ld_fwd_data  = '0;
`endif

    assign st_ready   = ~w_full;
    assign empty      = ~w_nempty;
    assign count      = r_count;
    assign dm_MemWr   = w_drain;
    assign dm_Data_in = w_drain ? w_head_e.data : '0;
    assign dm_lb_sel  = ~w_drain & ld_valid & ld_lb;
    assign dm_Addr    = w_drain ? 32'({w_head_e.addr, 2'b00})
                                : 32'(ld_addr[AW-1:0]);

    // Pointer and occupancy update; enqueue and drain may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PW'(1);
            end
            if (w_enq && !w_drain) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq && w_drain) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{addr: w_st_wa, data: st_data};
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer with a byte-addressed dm model.
// Write and load scoreboards plus a vector table and corner sequences.
module tb_mem_store_buffer;
    import mem_pkg::*;

`ifdef MEM_STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_lb = 1'b0;
    logic        ld_stall;
    logic        ld_fwd;
    logic [31:0] ld_fwd_data;
    logic        dm_MemWr;
    logic [31:0] dm_Addr;
    logic [31:0] dm_Data_in;
    logic        dm_lb_sel;
    logic        empty;
    logic [2:0]  count;

    always #5 clk = ~clk;

    mem_store_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_lb       (ld_lb),
        .ld_stall    (ld_stall),
        .ld_fwd      (ld_fwd),
        .ld_fwd_data (ld_fwd_data),
        .dm_MemWr    (dm_MemWr),
        .dm_Addr     (dm_Addr),
        .dm_Data_in  (dm_Data_in),
        .dm_lb_sel   (dm_lb_sel),
        .empty       (empty),
        .count       (count)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] lq[$];
    logic [7:0]  dmm  [1024];
    logic [31:0] refm [256];
    logic        p_we;
    logic [31:0] p_a;
    logic [31:0] p_d;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dm_read(input logic [31:0] a,
                                            input logic lb);
        logic [9:0] w;
        w = {a[9:2], 2'b00};
        if (lb) return {24'b0, dmm[a[9:0]]};
        return {dmm[w + 10'd3], dmm[w + 10'd2], dmm[w + 10'd1], dmm[w]};
    endfunction

    function automatic logic [31:0] ref_exp(input logic [31:0] a,
                                            input logic lb);
        logic [31:0] w;
        w = refm[a[9:2]];
        if (lb) return (w >> (8 * a[1:0])) & 32'hFF;
        return w;
    endfunction

    // Write monitor: capture the dm request and score it against program order.
    always @(negedge clk) begin
        p_we = dm_MemWr;
        p_a  = dm_Addr;
        p_d  = dm_Data_in;
        if (dm_MemWr) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dm_wr_unexpected: got addr %h want none",
                         dm_Addr);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("dm_wr_addr", dm_Addr, e.a);
                check("dm_wr_data", dm_Data_in, e.d);
            end
        end
    end

    // dm model: little-endian word write on posedge.
    always @(posedge clk) begin
        if (p_we) begin
            for (int b = 0; b < 4; b++) begin
                dmm[p_a[9:0] + 10'(b)] = p_d[8*b +: 8];
            end
        end
    end

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (st_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        st_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL st_timeout: got st_ready 0 want 1");
        end else begin
            wq.push_back('{{22'b0, a[9:2], 2'b00}, d});
            refm[a[9:2]] = d;
        end
    endtask

    task automatic ld(input logic [31:0] a, input logic lb,
                      output int stalls, output logic fwd,
                      output logic [31:0] res);
        bit ok;
        ok = 0;
        stalls = 0;
        fwd = 1'b0;
        res = '0;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_lb    = lb;
        lq.push_back(ref_exp(a, lb));
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (!ld_stall) begin
                ok  = 1;
                fwd = ld_fwd;
                res = ld_fwd ? ld_fwd_data : dm_read(dm_Addr, dm_lb_sel);
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ld_timeout: got ld_stall 1 want 0");
            lq.delete();
        end else begin
            check("ld_data", res, lq.pop_front());
        end
    endtask

    task automatic drain_all();
        for (int n = 0; n < 20 && !empty; n++) begin
            @(posedge clk);
            #1;
        end
        check("drained_empty", empty, 1);
    endtask

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] d;
        logic        lb;
        logic        exp_fwd;
        int          exp_stall;
        logic [31:0] exp;
    } vec_t;

    vec_t tv [10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : main
        int          stl;
        logic        fw;
        logic [31:0] rs;

        tv[0] = '{1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0};
        tv[1] = '{0, 0, 0, 0, 0, 0, 1};
        tv[2] = '{2, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF};
        tv[3] = '{1, 32'h20, 32'h11223344, 0, 0, 0, 0};
        tv[4] = '{1, 32'h20, 32'hAABBCCDD, 0, 0, 0, 0};
        tv[5] = '{2, 32'h21, 0, 1, FWD, FWD ? 0 : 1, 32'hCC};
        tv[6] = '{2, 32'h23, 0, 1, FWD, 0, 32'hAA};
        tv[7] = '{2, 32'h20, 0, 0, FWD, 0, 32'hAABBCCDD};
        tv[8] = '{0, 0, 0, 0, 0, 0, 32'(FWD)};
        tv[9] = '{2, 32'h12, 0, 1, 0, 0, 32'hAD};

        for (int i = 0; i < 1024; i++) dmm[i] = '0;
        for (int i = 0; i < 256; i++) refm[i] = '0;

        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_empty", empty, 1);
        check("rst_st_ready", st_ready, 1);
        check("rst_memwr", dm_MemWr, 0);
        check("rst_ld_stall", ld_stall, 0);
        check("rst_ld_fwd", ld_fwd, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            case (tv[i].op)
                0: begin
                    @(negedge clk);
                    check("tv_idle_wr", dm_MemWr, tv[i].exp[0]);
                    @(posedge clk);
                    #1;
                end
                1: st(tv[i].a, tv[i].d);
                default: begin
                    ld(tv[i].a, tv[i].lb, stl, fw, rs);
                    check("tv_ld_data", rs, tv[i].exp);
                    check("tv_ld_fwd", fw, tv[i].exp_fwd);
                    check("tv_ld_stall", stl, tv[i].exp_stall);
                    if (i == 2) check("tv_empty_after_lw", empty, 1);
                end
            endcase
        end
        drain_all();

        ld_valid = 1'b1;
        ld_addr  = 32'h300;
        ld_lb    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h100 + 32'(4 * i);
            st_data  = 32'hC0DE0000 + 32'(i);
            @(negedge clk);
            check("fill_count", 32'(count), i);
            check("fill_ready", st_ready, 1);
            check("fill_ld_stall", ld_stall, 1);
            @(posedge clk);
            #1;
            wq.push_back('{st_addr, st_data});
            refm[st_addr[9:2]] = st_data;
        end
        st_valid = 1'b0;
        check("full_count", 32'(count), 4);
        check("full_ready", st_ready, 0);
        ld(32'h300, 1'b0, stl, fw, rs);
        check("full_ld_stall_cycles", stl, 1);
        drain_all();

        for (int i = 0; i < 10; i++) begin
            st(32'(4 * i), 32'h5A000000 ^ (32'(i) * 32'h01010101));
            @(posedge clk);
            #1;
        end
        drain_all();
        for (int i = 0; i < 10; i++) begin
            ld(32'(4 * i), 1'b0, stl, fw, rs);
        end

        ld_valid = 1'b1;
        ld_addr  = 32'h300;
        st(32'h200, 32'h0000A001);
        st(32'h204, 32'h0000A002);
        ld_valid = 1'b0;
        check("same_pre_count", 32'(count), 2);
        st(32'h208, 32'h0000A003);
        check("same_post_count", 32'(count), 2);
        drain_all();
        ld(32'h200, 1'b0, stl, fw, rs);
        ld(32'h204, 1'b0, stl, fw, rs);
        ld(32'h208, 1'b0, stl, fw, rs);

        st(32'h43, 32'h5555AAAA);
        drain_all();
        ld(32'h40, 1'b0, stl, fw, rs);
        ld(32'h43, 1'b1, stl, fw, rs);

        ld_valid = 1'b1;
        ld_addr  = 32'h300;
        st(32'h180, 32'h0BAD0001);
        st(32'h184, 32'h0BAD0002);
        st(32'h188, 32'h0BAD0003);
        check("mid_count", 32'(count), 3);
        rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_memwr", dm_MemWr, 0);
        check("mid_rst_ready", st_ready, 1);
        #1;
        rst = 1'b1;
        ld_valid = 1'b0;
        wq.delete();
        for (int i = 0; i < 3; i++) begin
            refm[8'h60 + 8'(i)] = dm_read(32'h180 + 32'(4 * i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_memwr", dm_MemWr, 0);
        end
        @(posedge clk);
        #1;
        ld(32'h180, 1'b0, stl, fw, rs);
        check("wq_drained", wq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
